// File: rtl/tcm_dport_arb_if.sv
// Native dport bundle: a request held until accept, then an in-order ack carrying a response tag.
interface tcm_dport_arb_if;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic        cacheable;
    logic        invalidate;
    logic        writeback;
    logic        flush;
    logic [10:0] req_tag;
    logic        accept;
    logic        ack;
    logic        error;
    logic [31:0] data_rd;
    logic [10:0] resp_tag;

    modport master (
        output addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
        input  accept, ack, error, data_rd, resp_tag
    );

    modport slave (
        input  addr, data_wr, rd, wr, cacheable, invalidate, writeback, flush, req_tag,
        output accept, ack, error, data_rd, resp_tag
    );
endinterface

// File: rtl/tcm_dport_arb.sv
// Two-requester arbiter onto the TCM data port: round-robin with grant lock until accept,
// and an owner FIFO that steers each in-order ack back to the requester that issued it.
module tcm_dport_arb #(
    parameter int MAX_OUTSTANDING   = 2,
    parameter int MAX_OUTSTANDING_W = 1,
    parameter bit RESET_PRIORITY    = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    tcm_dport_arb_if.slave  m0,
    tcm_dport_arb_if.slave  m1,
    tcm_dport_arb_if.master s,
    output logic          spurious_ack_o,
    output logic          busy_o
);
    localparam int PW = MAX_OUTSTANDING_W;
    localparam int CW = MAX_OUTSTANDING_W + 1;
    localparam int FD = 1 << PW;

    logic          last_q;
    logic          lock_q;
    logic          lock_id_q;
    logic [FD-1:0] owner_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          spurious_q;

    logic [1:0]    req;
    logic          gnt_vld;
    logic          gnt_id;
    logic          sel_req;
    logic          full;
    logic          fwd;
    logic          acc;
    logic          pop;
    logic          head;

    assign req[0] = m0.rd | (|m0.wr) | m0.invalidate | m0.writeback | m0.flush;
    assign req[1] = m1.rd | (|m1.wr) | m1.invalidate | m1.writeback | m1.flush;

    // A held grant outranks the round-robin so an unaccepted request never changes under the slave.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (lock_q) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end else if (req[0] & req[1]) begin
            gnt_vld = 1'b1;
            gnt_id  = ~last_q;
        end else if (req[0] | req[1]) begin
            gnt_vld = 1'b1;
            gnt_id  = req[1];
        end
    end

    assign sel_req = gnt_id ? req[1] : req[0];
    assign full    = (count_q == CW'(MAX_OUTSTANDING));
    assign fwd     = gnt_vld & sel_req & ~full;
    assign acc     = fwd & s.accept & ~rst_i;
    assign pop     = s.ack & (count_q != '0) & ~rst_i;
    assign head    = owner_q[rd_ptr_q];

    // Request forwarding: strobes only when the request may actually issue.
    always_comb begin
        s.addr       = '0;
        s.data_wr    = '0;
        s.cacheable  = 1'b0;
        s.req_tag    = '0;
        s.rd         = 1'b0;
        s.wr         = '0;
        s.invalidate = 1'b0;
        s.writeback  = 1'b0;
        s.flush      = 1'b0;
        if (gnt_vld) begin
            s.addr      = gnt_id ? m1.addr      : m0.addr;
            s.data_wr   = gnt_id ? m1.data_wr   : m0.data_wr;
            s.cacheable = gnt_id ? m1.cacheable : m0.cacheable;
            s.req_tag   = gnt_id ? m1.req_tag   : m0.req_tag;
        end
        if (fwd) begin
            s.rd         = gnt_id ? m1.rd         : m0.rd;
            s.wr         = gnt_id ? m1.wr         : m0.wr;
            s.invalidate = gnt_id ? m1.invalidate : m0.invalidate;
            s.writeback  = gnt_id ? m1.writeback  : m0.writeback;
            s.flush      = gnt_id ? m1.flush      : m0.flush;
        end
    end

    assign m0.accept   = acc & ~gnt_id;
    assign m1.accept   = acc &  gnt_id;
    assign m0.ack      = pop & ~head;
    assign m1.ack      = pop &  head;
    assign m0.error    = pop & ~head & s.error;
    assign m1.error    = pop &  head & s.error;
    assign m0.data_rd  = s.data_rd;
    assign m1.data_rd  = s.data_rd;
    assign m0.resp_tag = s.resp_tag;
    assign m1.resp_tag = s.resp_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= RESET_PRIORITY;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            owner_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (acc) begin
                owner_q[wr_ptr_q] <= gnt_id;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                last_q            <= gnt_id;
                lock_q            <= 1'b0;
            end else if (fwd) begin
                lock_q    <= 1'b1;
                lock_id_q <= gnt_id;
            end
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({acc, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Ack with nothing outstanding is dropped but remembered.
            if (s.ack && count_q == '0)
                spurious_q <= 1'b1;
        end
    end

    assign spurious_ack_o = spurious_q;
    assign busy_o         = (count_q != '0);
endmodule

// File: tb/tb_tcm_dport_arb.sv
// Directed bench for tcm_dport_arb: single access, round-robin, lock, full stall, spurious/error, reset.
module tb_tcm_dport_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spurious, busy;
    int   checks = 0;
    int   errors = 0;

    tcm_dport_arb_if m0_if ();
    tcm_dport_arb_if m1_if ();
    tcm_dport_arb_if s_if ();

    tcm_dport_arb #(.MAX_OUTSTANDING(2), .MAX_OUTSTANDING_W(1), .RESET_PRIORITY(1'b0)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .m0             (m0_if.slave),
        .m1             (m1_if.slave),
        .s              (s_if.master),
        .spurious_ack_o (spurious),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_m0;
        m0_if.addr = '0; m0_if.data_wr = '0; m0_if.rd = 1'b0; m0_if.wr = '0;
        m0_if.cacheable = 1'b0; m0_if.invalidate = 1'b0; m0_if.writeback = 1'b0;
        m0_if.flush = 1'b0; m0_if.req_tag = '0;
    endtask

    task automatic clr_m1;
        m1_if.addr = '0; m1_if.data_wr = '0; m1_if.rd = 1'b0; m1_if.wr = '0;
        m1_if.cacheable = 1'b0; m1_if.invalidate = 1'b0; m1_if.writeback = 1'b0;
        m1_if.flush = 1'b0; m1_if.req_tag = '0;
    endtask

    initial begin
        logic win [4];
        win = '{1'b1, 1'b0, 1'b1, 1'b0};
        clr_m0();
        clr_m1();
        s_if.accept = 1'b0; s_if.ack = 1'b0; s_if.error = 1'b0;
        s_if.data_rd = '0; s_if.resp_tag = '0;

        // reset state
        tick(); tick();
        m0_if.rd = 1'b1; s_if.accept = 1'b1;
        #1;
        chk("rst_m0_accept", m0_if.accept, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spurious", spurious, 0);
        tick();
        rst = 1'b0;

        // single requester read
        m0_if.addr = 32'h100;
        #1;
        chk("single_accept", m0_if.accept, 1);
        chk("single_addr", s_if.addr, 32'h100);
        chk("single_s_rd", s_if.rd, 1);
        chk("single_m1_accept", m1_if.accept, 0);
        tick();
        clr_m0(); s_if.accept = 1'b0;
        s_if.ack = 1'b1; s_if.data_rd = 32'hCAFEF00D; s_if.resp_tag = 11'h005;
        #1;
        chk("single_ack", m0_if.ack, 1);
        chk("single_data", m0_if.data_rd, 32'hCAFEF00D);
        chk("single_tag", m0_if.resp_tag, 32'h005);
        chk("single_m1_ack", m1_if.ack, 0);
        chk("single_busy", busy, 1);
        tick();
        s_if.ack = 1'b0;
        #1;
        chk("single_idle_busy", busy, 0);

        // round-robin with acks trailing by one cycle
        m0_if.rd = 1'b1; m0_if.addr = 32'hA0;
        m1_if.rd = 1'b1; m1_if.addr = 32'hB0;
        s_if.accept = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.ack = (i > 0);
            if (i == 4) begin clr_m0(); clr_m1(); end
            #1;
            if (i < 4) begin
                chk($sformatf("rr_m1_accept%0d", i), m1_if.accept, win[i]);
                chk($sformatf("rr_m0_accept%0d", i), m0_if.accept, !win[i]);
                chk($sformatf("rr_addr%0d", i), s_if.addr, win[i] ? 32'hB0 : 32'hA0);
            end
            if (i > 0) begin
                chk($sformatf("rr_m1_ack%0d", i), m1_if.ack, win[i-1]);
                chk($sformatf("rr_m0_ack%0d", i), m0_if.ack, !win[i-1]);
            end
            tick();
        end
        s_if.ack = 1'b0; s_if.accept = 1'b0;

        // lock: m0 write held while m1 joins; last winner was m0, so m1 would otherwise win
        m0_if.wr = 4'hF; m0_if.addr = 32'h20; m0_if.data_wr = 32'h1234;
        #1;
        chk("lock_addr0", s_if.addr, 32'h20);
        chk("lock_accept0", m0_if.accept, 0);
        tick();
        m1_if.rd = 1'b1; m1_if.addr = 32'hB0;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk($sformatf("lock_addr%0d", i), s_if.addr, 32'h20);
            chk($sformatf("lock_wr%0d", i), s_if.wr, 32'hF);
            chk($sformatf("lock_m1_accept%0d", i), m1_if.accept, 0);
            tick();
        end
        s_if.accept = 1'b1;
        #1;
        chk("lock_m0_accept", m0_if.accept, 1);
        chk("lock_addr_acc", s_if.addr, 32'h20);
        tick();
        clr_m0();
        #1;
        chk("lock_m1_next", m1_if.accept, 1);
        chk("lock_m1_addr", s_if.addr, 32'hB0);
        tick();
        clr_m1(); s_if.accept = 1'b0; s_if.ack = 1'b1;
        #1;
        chk("lock_ack_m0", m0_if.ack, 1);
        tick();
        chk("lock_ack_m1", m1_if.ack, 1);
        chk("lock_ack_m1_not_m0", m0_if.ack, 0);
        tick();
        s_if.ack = 1'b0;

        // full stall
        m0_if.rd = 1'b1; m0_if.addr = 32'h300; s_if.accept = 1'b1;
        #1; chk("full_acc1", m0_if.accept, 1); tick();
        chk("full_acc2", m0_if.accept, 1); tick();
        chk("full_s_rd", s_if.rd, 0);
        chk("full_accept", m0_if.accept, 0);
        chk("full_busy", busy, 1);
        tick();
        s_if.ack = 1'b1;
        #1;
        chk("full_k_accept", m0_if.accept, 0);
        chk("full_k_ack", m0_if.ack, 1);
        tick();
        s_if.ack = 1'b0;
        chk("full_k1_accept", m0_if.accept, 1);
        chk("full_k1_s_rd", s_if.rd, 1);
        tick();
        clr_m0(); s_if.accept = 1'b0; s_if.ack = 1'b1;
        #1; chk("full_drain1", m0_if.ack, 1); tick();
        chk("full_drain2", m0_if.ack, 1); tick();
        s_if.ack = 1'b0;
        chk("full_drained_busy", busy, 0);

        // spurious ack while idle
        chk("spur_before", spurious, 0);
        s_if.ack = 1'b1;
        #1;
        chk("spur_m0_ack", m0_if.ack, 0);
        chk("spur_m1_ack", m1_if.ack, 0);
        tick();
        s_if.ack = 1'b0;
        chk("spur_flag", spurious, 1);

        // error routed to m1 only
        m1_if.rd = 1'b1; m1_if.addr = 32'h440; s_if.accept = 1'b1;
        #1; chk("err_accept", m1_if.accept, 1); tick();
        clr_m1(); s_if.accept = 1'b0; s_if.ack = 1'b1; s_if.error = 1'b1;
        #1;
        chk("err_m1_ack", m1_if.ack, 1);
        chk("err_m1_error", m1_if.error, 1);
        chk("err_m0_error", m0_if.error, 0);
        tick();
        s_if.ack = 1'b0; s_if.error = 1'b0;

        // reset with two requests in flight
        m0_if.rd = 1'b1; s_if.accept = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rstmid_accept", m0_if.accept, 0);
        tick();
        rst = 1'b0; clr_m0(); s_if.accept = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_spur_clr", spurious, 0);
        s_if.ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("rstmid_m0_ack%0d", i), m0_if.ack, 0);
            chk($sformatf("rstmid_m1_ack%0d", i), m1_if.ack, 0);
            tick();
        end
        s_if.ack = 1'b0;
        chk("rstmid_spur", spurious, 1);
        chk("rstmid_busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
